bpu_override_pipe: RTL and testbench

- Parametrised N-stage branch-prediction pipeline controller.
- Owns the fetch-PC register, per-stage valid/start-PC/stream-index registers, the stage-to-stage payload pipeline, override arbitration and the stream-index allocator.
- Sits between the individual predictors (uBTB at stage 0, BTB/TAGE/RAS in later stages) and the FSQ. It generalises the fixed two-stage s1/s2 override scheme to STAGES stages, with a latest-stage-wins override rule.

---
 rtl/bpu_override_pipe_pkg.sv | 6 +
 rtl/bpu_override_pipe_redirect_arbiter.sv | 22 ++
 rtl/bpu_override_pipe.sv | 152 +++++++++++++++
 tb/tb_bpu_override_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_override_pipe_pkg.sv
// bpu_override_pipe_pkg: shared constants and types for the branch-prediction override pipeline.
package bpu_override_pipe_pkg;
    localparam int BPU_STAGE_MAX = 4;
    localparam int STAGE_NUM_W = 2;
    typedef logic [STAGE_NUM_W-1:0] stage_num_t;
endpackage

// File: rtl/bpu_override_pipe_redirect_arbiter.sv
// bpu_redirect_arbiter: selects the highest valid redirecting stage (latest stage holds the oldest stream).
module bpu_redirect_arbiter
    import bpu_override_pipe_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic [STAGES-1:1] valid,
    input  logic [STAGES-1:1] redirect,
    output logic              any_red,
    output stage_num_t        red_k
);
    always_comb begin
        any_red = 1'b0;
        red_k = '0;
        for (int k = 1; k < STAGES; k++) begin
            if (valid[k] && redirect[k]) begin
                any_red = 1'b1;
                red_k = stage_num_t'(k);
            end
        end
    end
endmodule

// File: rtl/bpu_override_pipe.sv
// bpu_override_pipe: N-stage prediction pipeline with latest-stage-wins override and FSQ index allocation.
// Defining BPU_OVERRIDE_PERF_EN adds per-stage redirect and stall performance counters.
module bpu_override_pipe
    import bpu_override_pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int VADDR_W = 39,
    parameter int PRED_W = 128,
    parameter int IDX_W = 5,
    parameter logic [VADDR_W-1:0] RESET_PC = 39'h80000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [VADDR_W-1:0]          flush_pc,
    input  logic [IDX_W:0]              flush_idx,
    input  logic                        fsq_stall,
    input  logic [STAGES-1:0]           stage_ready,
    input  logic [STAGES-1:0]           stage_redirect,
    input  logic [STAGES*VADDR_W-1:0]   stage_target,
    input  logic [STAGES*PRED_W-1:0]    stage_payload,
    output logic [VADDR_W-1:0]          pc,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*VADDR_W-1:0]   stage_pc,
    output logic [(STAGES-1)*PRED_W-1:0] stage_in_payload,
    output logic                        pred_en,
    output logic                        pred_redirect,
    output logic [1:0]                  pred_stage,
    output logic [IDX_W:0]              pred_idx,
    output logic [PRED_W-1:0]           pred_payload,
    output logic                        last_en,
    output logic [IDX_W:0]              last_idx
`ifdef BPU_OVERRIDE_PERF_EN
    ,
    output logic [STAGES*32-1:0]        perf_redirect_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);
    typedef logic [IDX_W:0] stream_idx_t;
    typedef struct packed {
        logic                en;
        logic [VADDR_W-1:0]  start_pc;
        stream_idx_t         idx;
        logic [PRED_W-1:0]   payload;
    } stage_reg_t;

    stage_reg_t          sr [1:STAGES-1];
    stage_reg_t          cur [BPU_STAGE_MAX];
    logic [VADDR_W-1:0]  tgt [BPU_STAGE_MAX];
    logic [PRED_W-1:0]   pl [BPU_STAGE_MAX];
    logic                v0;
    stream_idx_t         alloc;
    logic                stall, go, any_red;
    stage_num_t          red_k;
    logic [STAGES-1:1]   kill;
    logic                unused_redirect0;

    assign unused_redirect0 = stage_redirect[0];
    assign stall = fsq_stall | ~&stage_ready;
    assign go = ~stall & ~flush;

    // Stage 0 is virtual: its stream is the live pc with the allocator's next index.
    always_comb begin
        for (int k = 0; k < BPU_STAGE_MAX; k++) begin
            cur[k] = '0;
            tgt[k] = '0;
            pl[k] = '0;
        end
        cur[0] = '{en: v0, start_pc: pc, idx: alloc, payload: '0};
        for (int k = 1; k < STAGES; k++) cur[k] = sr[k];
        for (int k = 0; k < STAGES; k++) begin
            tgt[k] = stage_target[k*VADDR_W +: VADDR_W];
            pl[k] = stage_payload[k*PRED_W +: PRED_W];
        end
    end

    always_comb begin
        stage_valid = '0;
        stage_pc = '0;
        stage_in_payload = '0;
        kill = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_valid[k] = cur[k].en;
            stage_pc[k*VADDR_W +: VADDR_W] = cur[k].start_pc;
        end
        for (int k = 1; k < STAGES; k++) begin
            stage_in_payload[(k-1)*PRED_W +: PRED_W] = sr[k].payload;
            kill[k] = any_red && (k <= int'(red_k));
        end
    end

    bpu_redirect_arbiter #(.STAGES(STAGES)) u_arb (
        .valid    (stage_valid[STAGES-1:1]),
        .redirect (stage_redirect[STAGES-1:1]),
        .any_red  (any_red),
        .red_k    (red_k)
    );

    assign pred_en = (any_red | v0) & go;
    assign pred_redirect = any_red & go;
    assign pred_stage = any_red ? red_k : '0;
    assign pred_idx = any_red ? cur[red_k].idx : alloc;
    assign pred_payload = any_red ? pl[red_k] : (v0 ? pl[0] : '0);
    assign last_en = stage_valid[STAGES-1] & go;
    assign last_idx = sr[STAGES-1].idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            v0 <= 1'b0;
            alloc <= '0;
            for (int k = 1; k < STAGES; k++) sr[k] <= '0;
        end else begin
            v0 <= 1'b1;
            if (flush) begin
                pc <= flush_pc;
                alloc <= flush_idx + stream_idx_t'(1);
                for (int k = 1; k < STAGES; k++) sr[k].en <= 1'b0;
            end else if (!stall && v0) begin
                pc <= any_red ? tgt[red_k] : tgt[0];
                alloc <= (any_red ? cur[red_k].idx : alloc) + stream_idx_t'(1);
                // The redirecting stage itself shifts on with its own payload; younger ones die.
                for (int k = 1; k < STAGES; k++) begin
                    if (kill[k]) sr[k].en <= 1'b0;
                    else sr[k] <= '{en: cur[k-1].en, start_pc: cur[k-1].start_pc,
                                    idx: cur[k-1].idx, payload: pl[k-1]};
                end
            end
        end
    end

`ifdef BPU_OVERRIDE_PERF_EN
    logic [31:0] red_cnt [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) red_cnt[k] <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++)
                if (pred_redirect && red_k == stage_num_t'(k) && ~&red_cnt[k])
                    red_cnt[k] <= red_cnt[k] + 32'd1;
            if (stall && ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

    always_comb begin
        perf_redirect_cnt = '0;
        for (int k = 0; k < STAGES; k++) perf_redirect_cnt[k*32 +: 32] = red_cnt[k];
    end
`endif
endmodule

// File: tb/tb_bpu_override_pipe.sv
// tb_bpu_override_pipe: self-checking bench for bpu_override_pipe with STAGES=3.
module tb_bpu_override_pipe;
    localparam int S = 3;
    localparam int VW = 39;
    localparam int PW = 128;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic fsq_stall = 1'b0;
    logic [VW-1:0] flush_pc = '0;
    logic [IW:0] flush_idx = '0;
    logic [S-1:0] stage_ready = '1;
    logic [S-1:0] stage_redirect = '0;
    logic [S*VW-1:0] stage_target;
    logic [S*PW-1:0] stage_payload;
    logic [VW-1:0] pc;
    logic [S-1:0] stage_valid;
    logic [S*VW-1:0] stage_pc;
    logic [(S-1)*PW-1:0] stage_in_payload;
    logic pred_en, pred_redirect, last_en;
    logic [1:0] pred_stage;
    logic [IW:0] pred_idx, last_idx;
    logic [PW-1:0] pred_payload;
    logic [VW-1:0] tgt1 = '0;
    logic [VW-1:0] tgt2 = '0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [IW:0] idx;
        logic [VW-1:0] pc;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic fl;
        logic st;
        logic [2:0] rdy;
        logic [2:0] red;
        logic en;
        logic rd;
        logic [1:0] stg;
        logic [IW:0] idx;
        logic last;
    } row_t;
    row_t rows [10];

    always #5 clk = ~clk;

    // Stage 0 predicts sequential fetch; payloads tag the stage and carry the stage's start pc.
    assign stage_target = {tgt2, tgt1, pc + 39'd32};
    for (genvar g = 0; g < S; g++) begin : g_pl
        assign stage_payload[g*PW +: PW] = {8'(g + 1), 81'b0, stage_pc[g*VW +: VW]};
    end

    bpu_override_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .flush_idx        (flush_idx),
        .fsq_stall        (fsq_stall),
        .stage_ready      (stage_ready),
        .stage_redirect   (stage_redirect),
        .stage_target     (stage_target),
        .stage_payload    (stage_payload),
        .pc               (pc),
        .stage_valid      (stage_valid),
        .stage_pc         (stage_pc),
        .stage_in_payload (stage_in_payload),
        .pred_en          (pred_en),
        .pred_redirect    (pred_redirect),
        .pred_stage       (pred_stage),
        .pred_idx         (pred_idx),
        .pred_payload     (pred_payload),
        .last_en          (last_en),
        .last_idx         (last_idx)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_flush(input logic [VW-1:0] p, input logic [IW:0] x);
        @(negedge clk);
        flush = 1'b1;
        flush_pc = p;
        flush_idx = x;
        @(negedge clk);
        flush = 1'b0;
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int first_last;
        int pops;
        sb_t e;
        rows[0] = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 2'd0, 6'd12, 1'b1};
        rows[1] = '{1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 1'b1, 2'd1, 6'd11, 1'b1};
        rows[2] = '{1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 1'b1, 2'd2, 6'd10, 1'b1};
        rows[3] = '{1'b0, 1'b0, 3'b111, 3'b110, 1'b1, 1'b1, 2'd2, 6'd10, 1'b1};
        rows[4] = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 1'b0, 2'd0, 6'd12, 1'b1};
        rows[5] = '{1'b0, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        rows[6] = '{1'b0, 1'b0, 3'b101, 3'b100, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        rows[7] = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        rows[8] = '{1'b1, 1'b1, 3'b011, 3'b010, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        rows[9] = '{1'b0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 39'h80000000);
        chk("rst_valid", stage_valid, 0);
        chk("rst_pred_en", pred_en, 0);
        chk("rst_pred_redirect", pred_redirect, 0);
        chk("rst_pred_idx", pred_idx, 0);
        chk("rst_pred_payload", pred_payload, 0);
        chk("rst_last_en", last_en, 0);
        chk("rst_last_idx", last_idx, 0);

        @(negedge clk);
        rst = 1'b0;
        first_last = -1;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("run_pc", pc, 39'h80000000 + 39'(32 * i));
            chk("run_pred_idx", pred_idx, 6'(i));
            chk("run_pred_en", pred_en, 1);
            sb.push_back('{6'(i), 39'h80000000 + 39'(32 * i)});
            if (last_en) begin
                if (first_last < 0) first_last = i;
                pops++;
                e = sb.pop_front();
                chk("sb_last_idx", last_idx, e.idx);
                chk("sb_last_pc", stage_pc[2*VW +: VW], e.pc);
                chk("sb_last_payload", stage_in_payload[PW +: PW], {8'd2, 81'b0, e.pc});
            end
        end
        chk("first_last_latency", first_last, 2);
        chk("sb_pops", pops, 6);
        chk("run_valid_full", stage_valid, 3'b111);
        sb.delete();

        @(negedge clk);
        flush = 1'b1;
        flush_pc = 39'h80002000;
        flush_idx = 6'h3F;
        fsq_stall = 1'b1;
        stage_redirect = 3'b010;
        tgt1 = 39'h80009000;
        #1;
        chk("flush_pred_en", pred_en, 0);
        chk("flush_pred_redirect", pred_redirect, 0);
        chk("flush_last_en", last_en, 0);
        @(negedge clk);
        flush = 1'b0;
        fsq_stall = 1'b0;
        stage_redirect = 3'b000;
        #1;
        chk("flush_pc", pc, 39'h80002000);
        chk("flush_valid", stage_valid, 3'b001);
        chk("flush_alloc", pred_idx, 6'h00);
        chk("flush_resume_en", pred_en, 1);

        do_flush(39'h80003000, 6'd30);
        chk("wrap_pre_idx", pred_idx, 6'h1F);
        adv(1);
        chk("wrap_post_idx", pred_idx, 6'h20);
        chk("wrap_pc", pc, 39'h80003020);

        do_flush(39'h80003000, 6'd1);
        adv(4);
        stage_redirect = 3'b100;
        tgt2 = 39'h80001000;
        #1;
        chk("red2_pred_en", pred_en, 1);
        chk("red2_pred_redirect", pred_redirect, 1);
        chk("red2_pred_stage", pred_stage, 2);
        chk("red2_pred_idx", pred_idx, 6'd4);
        chk("red2_pred_payload", pred_payload, {8'd3, 81'b0, 39'h80003040});
        @(negedge clk);
        stage_redirect = 3'b000;
        #1;
        chk("red2_next_pc", pc, 39'h80001000);
        chk("red2_valid", stage_valid, 3'b001);
        chk("red2_alloc", pred_idx, 6'd5);

        do_flush(39'h80003000, 6'd1);
        adv(4);
        stage_redirect = 3'b110;
        tgt1 = 39'h80004000;
        tgt2 = 39'h80005000;
        #1;
        chk("dual_pred_stage", pred_stage, 2);
        chk("dual_pred_idx", pred_idx, 6'd4);
        @(negedge clk);
        stage_redirect = 3'b000;
        #1;
        chk("dual_next_pc", pc, 39'h80005000);
        chk("dual_alloc", pred_idx, 6'd5);

        do_flush(39'h80007000, 6'd9);
        adv(2);
        fsq_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            flush = rows[i].fl;
            flush_pc = 39'h8000F000;
            fsq_stall = rows[i].st;
            stage_ready = rows[i].rdy;
            stage_redirect = rows[i].red;
            #1;
            chk($sformatf("tbl%0d_pred_en", i), pred_en, rows[i].en);
            chk($sformatf("tbl%0d_pred_redirect", i), pred_redirect, rows[i].rd);
            chk($sformatf("tbl%0d_last_en", i), last_en, rows[i].last);
            if (rows[i].en) begin
                chk($sformatf("tbl%0d_pred_stage", i), pred_stage, rows[i].stg);
                chk($sformatf("tbl%0d_pred_idx", i), pred_idx, rows[i].idx);
            end
            flush = 1'b0;
            fsq_stall = 1'b1;
            stage_ready = '1;
            stage_redirect = 3'b000;
        end
        @(negedge clk);
        #1;
        chk("tbl_hold_pc", pc, 39'h80007040);
        chk("tbl_hold_valid", stage_valid, 3'b111);

        stage_redirect = 3'b010;
        tgt1 = 39'h80006000;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pred_en", pred_en, 0);
            chk("stall_pc", pc, 39'h80007040);
            @(negedge clk);
            #1;
        end
        fsq_stall = 1'b0;
        #1;
        chk("unstall_pred_redirect", pred_redirect, 1);
        chk("unstall_pred_stage", pred_stage, 1);
        chk("unstall_pred_idx", pred_idx, 6'd11);
        @(negedge clk);
        stage_redirect = 3'b000;
        #1;
        chk("unstall_next_pc", pc, 39'h80006000);
        chk("unstall_valid", stage_valid, 3'b101);
        chk("unstall_alloc", pred_idx, 6'd12);
        chk("unstall_last_idx", last_idx, 6'd11);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 39'h80000000);
        chk("arst_valid", stage_valid, 0);
        chk("arst_pred_en", pred_en, 0);
        chk("arst_last_en", last_en, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
